// File: rtl/piece_move_ctrl.sv
// -----------------------------------------------------------------------------
// piece_move_ctrl
//
// Movement controller for the falling piece. It turns keyboard edges and a
// frame-tick driven gravity timer into candidate positions. Each candidate is
// sent to an external collision checker. The controller commits the candidate
// when the checker accepts it, and locks the piece when a gravity step is
// refused.
//
// Build option:
//   SOFT_DROP_EN - when defined, the S key requests a one-row soft drop and a
//                  committed soft drop restarts the gravity timer. When it is
//                  undefined, the S key is ignored entirely.
// -----------------------------------------------------------------------------
module piece_move_ctrl #(
    parameter int         GRAV_PERIOD = 30,     // frame ticks per gravity step, 1..255
    parameter logic [3:0] X_SPAWN     = 4'd4,   // spawn column
    parameter logic [4:0] Y_SPAWN     = 5'd0    // spawn row
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        frame_tick,
    input  logic        game_en,
    output logic        chk_req,
    output logic [3:0]  chk_x,
    output logic [4:0]  chk_y,
    output logic [1:0]  chk_rot,
    input  logic        chk_done,
    input  logic        chk_ok,
    output logic [3:0]  piece_x,
    output logic [4:0]  piece_y,
    output logic [1:0]  shape_rot,
    output logic        lock_pulse
);

    // Keyboard codes understood by the controller.
    localparam logic [15:0] KEY_W = 16'h001A;   // rotate
    localparam logic [15:0] KEY_A = 16'h0004;   // left
    localparam logic [15:0] KEY_D = 16'h0007;   // right
    localparam logic [15:0] KEY_S = 16'h0016;   // soft drop

    localparam logic [7:0] GRAV_LAST = 8'(GRAV_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    // One code for every kind of request the FSM can serve. ACT_GRAV is
    // never held in the key slot. It only tags the request in flight.
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_ROT   = 3'd1,
        ACT_LEFT  = 3'd2,
        ACT_RIGHT = 3'd3,
        ACT_DROP  = 3'd4,
        ACT_GRAV  = 3'd5
    } act_t;

    state_t      state_q, state_d;

    logic [15:0] key_q;          // keycode as seen last cycle
    act_t        key_act;        // action encoded by the current keycode
    logic        key_fire;       // keycode just changed to an action code

    act_t        key_pend_q;     // newest unserved key action (ACT_NONE if none)
    logic        grav_pend_q;    // unserved gravity step
    logic [7:0]  grav_cnt_q;     // frame ticks since the last gravity step
    logic        grav_expire;    // this tick completes a gravity period

    act_t        srv_q;          // request currently being checked
    act_t        sel_act;        // request chosen in IDLE this cycle

    logic        issue;          // launch a check this cycle
    logic        commit;         // checker accepted the in-flight candidate
    logic        do_lock;        // LOCK state housekeeping this cycle

    logic [3:0]  cand_x;
    logic [4:0]  cand_y;
    logic [1:0]  cand_rot;

    logic [3:0]  piece_x_q;
    logic [4:0]  piece_y_q;
    logic [1:0]  shape_rot_q;
    logic [3:0]  chk_x_q;
    logic [4:0]  chk_y_q;
    logic [1:0]  chk_rot_q;

    // Decode the keyboard into an action. An undecoded key means "no action".
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        key_act = ACT_NONE;
        case (keycode)
            KEY_W:   key_act = ACT_ROT;
            KEY_A:   key_act = ACT_LEFT;
            KEY_D:   key_act = ACT_RIGHT;
`ifdef SOFT_DROP_EN
            KEY_S:   key_act = ACT_DROP;
`endif
            default: key_act = ACT_NONE;
        endcase
    end

    // An action fires only on the cycle the key code changes. A held key
    // keeps key_q equal to keycode, so it cannot fire again.
    assign key_fire    = (keycode != key_q) && (key_act != ACT_NONE);
    assign grav_expire = game_en && frame_tick && (grav_cnt_q == GRAV_LAST);

    // FSM next-state logic and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        commit  = 1'b0;
        do_lock = 1'b0;
        sel_act = ACT_NONE;
        case (state_q)
            ST_IDLE: begin
                // Gravity outranks any key. The single key slot already holds
                // only the newest key, so no further arbitration is needed.
                if (game_en && (grav_pend_q || (key_pend_q != ACT_NONE))) begin
                    issue   = 1'b1;
                    sel_act = grav_pend_q ? ACT_GRAV : key_pend_q;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // The check always completes, even if game_en has dropped.
                if (chk_done) begin
                    if (chk_ok) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (srv_q == ACT_GRAV) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                do_lock = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Candidate position for the request being launched. Arithmetic wraps
    // freely; the checker decides whether the result is on the board.
    always_comb begin
        cand_x   = piece_x_q;
        cand_y   = piece_y_q;
        cand_rot = shape_rot_q;
        case (sel_act)
            ACT_GRAV:  cand_y   = piece_y_q + 5'd1;
`ifdef SOFT_DROP_EN
            ACT_DROP:  cand_y   = piece_y_q + 5'd1;
`endif
            ACT_ROT:   cand_rot = shape_rot_q + 2'd1;
            ACT_LEFT:  cand_x   = piece_x_q - 4'd1;
            ACT_RIGHT: cand_x   = piece_x_q + 4'd1;
            default:   ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Key history and pending key action.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q      <= 16'h0000;
            key_pend_q <= ACT_NONE;
        end else begin
            key_q <= keycode;
            // A lock wipes the slot. Any edge in that cycle is consumed by
            // key_q and is lost. A fresh edge overrides both an older pending
            // key and the clear caused by launching it, so a key that arrives
            // while a check is running is kept for later.
            if (do_lock) begin
                key_pend_q <= ACT_NONE;
            end else if (key_fire) begin
                key_pend_q <= key_act;
            end else if (issue && (sel_act != ACT_GRAV)) begin
                key_pend_q <= ACT_NONE;
            end
        end
    end

    // Gravity timer and gravity pending flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grav_cnt_q  <= 8'd0;
            grav_pend_q <= 1'b0;
        end else begin
            if (do_lock) begin
                grav_pend_q <= 1'b0;
            end else if (grav_expire) begin
                grav_pend_q <= 1'b1;
            end else if (issue && (sel_act == ACT_GRAV)) begin
                grav_pend_q <= 1'b0;
            end

            if (do_lock) begin
                grav_cnt_q <= 8'd0;
`ifdef SOFT_DROP_EN
            end else if (commit && (srv_q == ACT_DROP)) begin
                // A player-driven drop restarts the gravity period.
                grav_cnt_q <= 8'd0;
`endif
            end else if (game_en && frame_tick) begin
                grav_cnt_q <= grav_expire ? 8'd0 : grav_cnt_q + 8'd1;
            end
        end
    end

    // Candidate registers: loaded at launch and held for the whole check.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            chk_x_q   <= 4'd0;
            chk_y_q   <= 5'd0;
            chk_rot_q <= 2'd0;
            srv_q     <= ACT_NONE;
        end else if (issue) begin
            chk_x_q   <= cand_x;
            chk_y_q   <= cand_y;
            chk_rot_q <= cand_rot;
            srv_q     <= sel_act;
        end
    end

    // Committed piece: takes an accepted candidate, or respawns on lock.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            piece_x_q   <= X_SPAWN;
            piece_y_q   <= Y_SPAWN;
            shape_rot_q <= 2'd0;
        end else if (do_lock) begin
            piece_x_q   <= X_SPAWN;
            piece_y_q   <= Y_SPAWN;
            shape_rot_q <= 2'd0;
        end else if (commit) begin
            piece_x_q   <= chk_x_q;
            piece_y_q   <= chk_y_q;
            shape_rot_q <= chk_rot_q;
        end
    end

    assign chk_req    = (state_q == ST_CHECK);
    assign lock_pulse = (state_q == ST_LOCK);
    assign chk_x      = chk_x_q;
    assign chk_y      = chk_y_q;
    assign chk_rot    = chk_rot_q;
    assign piece_x    = piece_x_q;
    assign piece_y    = piece_y_q;
    assign shape_rot  = shape_rot_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piece_move_ctrl
//
// Scoreboard bench. The stimulus pushes each expected checker request
// {x, y, rot} into a queue. A monitor acts as the collision checker: it pops
// and compares the queue whenever a new chk_req appears, answers after
// resp_delay cycles, and verifies the commit one cycle after an accepted check.
// -----------------------------------------------------------------------------
module tb_piece_move_ctrl;

    localparam logic [15:0] KEY_W = 16'h001A;
    localparam logic [15:0] KEY_A = 16'h0004;
    localparam logic [15:0] KEY_D = 16'h0007;
    localparam logic [15:0] KEY_S = 16'h0016;

    logic        Clk;
    logic        Reset;
    logic [15:0] keycode;
    logic        frame_tick;
    logic        game_en;
    logic        chk_req;
    logic [3:0]  chk_x;
    logic [4:0]  chk_y;
    logic [1:0]  chk_rot;
    logic        chk_done;
    logic        chk_ok;
    logic [3:0]  piece_x;
    logic [4:0]  piece_y;
    logic [1:0]  shape_rot;
    logic        lock_pulse;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          req_seen  = 0;
    int          exp_total = 0;
    int          lock_cnt  = 0;
    int          resp_delay = 2;
    bit          ok_mode   = 1'b1;

    logic [10:0] exp_q[$];

    piece_move_ctrl #(
        .GRAV_PERIOD (3),
        .X_SPAWN     (4'd4),
        .Y_SPAWN     (5'd0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .game_en    (game_en),
        .chk_req    (chk_req),
        .chk_x      (chk_x),
        .chk_y      (chk_y),
        .chk_rot    (chk_rot),
        .chk_done   (chk_done),
        .chk_ok     (chk_ok),
        .piece_x    (piece_x),
        .piece_y    (piece_y),
        .shape_rot  (shape_rot),
        .lock_pulse (lock_pulse)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] pack(input logic [3:0] x, input logic [4:0] y, input logic [1:0] r);
        return {x, y, r};
    endfunction

    task automatic expect_req(input logic [3:0] x, input logic [4:0] y, input logic [1:0] r);
        exp_q.push_back(pack(x, y, r));
        exp_total++;
    endtask

    // Checker model and scoreboard monitor.
    logic [10:0] cap;
    int          req_age = 0;
    bit          done_prev = 1'b0;
    bit          done_ok_prev = 1'b0;
    bit          lock_prev = 1'b0;

    always @(negedge Clk) begin
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        if (done_prev) begin
            check("req_drop", chk_req, 0);
            if (done_ok_prev)
                check("commit", pack(piece_x, piece_y, shape_rot), cap);
        end
        done_prev    = 1'b0;
        done_ok_prev = 1'b0;
        if (Reset || !chk_req) begin
            req_age = 0;
        end else begin
            if (req_age == 0) begin
                req_seen++;
                cap = pack(chk_x, chk_y, chk_rot);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got x=%0d y=%0d rot=%0d, expected no request (t=%0t)",
                             chk_x, chk_y, chk_rot, $time);
                end else begin
                    check("chk_cand", cap, exp_q.pop_front());
                end
            end else begin
                check("chk_stable", pack(chk_x, chk_y, chk_rot), cap);
            end
            req_age++;
            if (req_age == resp_delay) begin
                chk_done     = 1'b1;
                chk_ok       = ok_mode;
                done_prev    = 1'b1;
                done_ok_prev = ok_mode;
            end
        end
        if (lock_pulse) begin
            lock_cnt++;
            check("lock_width", lock_prev, 0);
        end
        lock_prev = lock_pulse;
    end

    task automatic wait_quiet();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && !chk_req) quiet++;
            else quiet = 0;
        end
        check("quiet_bound", (quiet >= 4) ? 1 : 0, 1);
    endtask

    task automatic press(input logic [15:0] code);
        keycode = code;
        repeat (4) @(negedge Clk);
        keycode = 16'h0000;
        repeat (2) @(negedge Clk);
        wait_quiet();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        keycode    = 16'h0000;
        frame_tick = 1'b0;
        game_en    = 1'b1;
        chk_done   = 1'b0;
        chk_ok     = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_piece", pack(piece_x, piece_y, shape_rot), pack(4, 0, 0));
        check("rst_chk",   pack(chk_x, chk_y, chk_rot), pack(0, 0, 0));
        check("rst_req",   chk_req, 0);
        check("rst_lock",  lock_pulse, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Rotate: two-cycle latency, and a held key must not repeat.
        expect_req(4, 0, 1);
        keycode = KEY_W;
        @(negedge Clk);
        check("lat_cyc1", chk_req, 0);
        @(negedge Clk);
        check("lat_cyc2", chk_req, 1);
        repeat (100) @(negedge Clk);
        keycode = 16'h0000;
        wait_quiet();
        check("rot_1", shape_rot, 1);
        expect_req(4, 0, 2);
        press(KEY_W);
        check("rot_2", shape_rot, 2);
        expect_req(4, 0, 3);
        press(KEY_W);
        expect_req(4, 0, 0);
        press(KEY_W);
        check("rot_wrap", shape_rot, 0);

        // Left moves down to column 0, then a refused wrap to 15.
        expect_req(3, 0, 0);
        press(KEY_A);
        check("left_4to3", piece_x, 3);
        expect_req(2, 0, 0);
        press(KEY_A);
        expect_req(1, 0, 0);
        press(KEY_A);
        expect_req(0, 0, 0);
        press(KEY_A);
        check("left_to0", piece_x, 0);
        ok_mode = 1'b0;
        expect_req(15, 0, 0);
        press(KEY_A);
        check("left_refused", piece_x, 0);
        check("no_lock_on_key", lock_cnt, 0);
        ok_mode = 1'b1;
        expect_req(1, 0, 0);
        press(KEY_D);
        check("right_0to1", piece_x, 1);

        // Gravity: six ticks at period 3 give two steps.
        expect_req(1, 1, 0);
        tick(3);
        expect_req(1, 2, 0);
        tick(3);
        wait_quiet();
        check("grav_two", pack(piece_x, piece_y, shape_rot), pack(1, 2, 0));

        // Gravity expiry and D edge together: gravity goes first.
        expect_req(1, 3, 0);
        expect_req(2, 3, 0);
        tick(2);
        frame_tick = 1'b1;
        keycode    = KEY_D;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge Clk);
        keycode = 16'h0000;
        wait_quiet();
        check("grav_then_d", pack(piece_x, piece_y, shape_rot), pack(2, 3, 0));

        // Fall to row 17, then a refused gravity step locks the piece.
        for (int y = 3; y < 17; y++) begin
            expect_req(2, 5'(y + 1), 0);
            tick(3);
            wait_quiet();
        end
        check("at_row17", piece_y, 17);
        ok_mode    = 1'b0;
        resp_delay = 8;
        expect_req(2, 18, 0);
        tick(3);
        tick(1);                // lands during the check; the lock must clear it
        wait_quiet();
        check("lock_once", lock_cnt, 1);
        check("respawn", pack(piece_x, piece_y, shape_rot), pack(4, 0, 0));
        ok_mode    = 1'b1;
        resp_delay = 2;
        tick(2);
        repeat (5) @(negedge Clk);
        expect_req(4, 1, 0);
        tick(1);
        wait_quiet();
        check("cnt_cleared", piece_y, 1);

        // game_en low: moves and gravity wait, then the key is served.
        game_en = 1'b0;
        keycode = KEY_D;
        repeat (3) @(negedge Clk);
        keycode = 16'h0000;
        tick(3);
        repeat (10) @(negedge Clk);
        check("frozen", chk_req, 0);
        expect_req(5, 1, 0);
        game_en = 1'b1;
        wait_quiet();
        check("resumed", pack(piece_x, piece_y, shape_rot), pack(5, 1, 0));

        // Soft drop key.
`ifdef SOFT_DROP_EN
        expect_req(5, 2, 0);
        press(KEY_S);
        check("soft_drop", piece_y, 2);
`else
        press(KEY_S);
        check("s_ignored", pack(piece_x, piece_y, shape_rot), pack(5, 1, 0));
`endif

        check("req_total", req_seen, exp_total);
        check("queue_empty", exp_q.size(), 0);
        check("lock_total", lock_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piece_move_ctrl.md
PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

Interface
REQ-001 SHALL have parameter GRAV_PERIOD, 30, frame_tick pulses per gravity step (range 1..255).
REQ-002 SHALL have parameter X_SPAWN, 4, column loaded into piece_x at reset and after lock.
REQ-003 SHALL have parameter Y_SPAWN, 0, row loaded into piece_y at reset and after lock.
REQ-004 SHALL have ports:
- Clk  in  1  single clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  16  keyboard code; W=0x001A rotate, A=0x0004 left, D=0x0007 right, S=0x0016 soft drop, 0x0000 = none.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_en  in  1  when 0, freezes gravity and accepts no new moves.
- chk_req  out  1  request to the collision checker.
- chk_x  out  4  candidate column.
- chk_y  out  5  candidate row.
- chk_rot  out  2  candidate rotation.
- chk_done  in  1  one-cycle checker completion pulse.
- chk_ok  in  1  candidate legal; valid only with chk_done.
- piece_x  out  4  committed column.
- piece_y  out  5  committed row.
- shape_rot  out  2  committed rotation.
- lock_pulse  out  1  one-cycle pulse when the piece locks.

Function
REQ-005 SHALL edge-detect keycode: a key action SHALL fire once, in the cycle the registered keycode changes to that key's code; a held key SHALL NOT repeat.
REQ-006 SHALL latch each fired key action as pending until it is served. A new key action SHALL overwrite any older pending key action.
REQ-007 SHALL count frame_tick while game_en=1. When the count reaches GRAV_PERIOD, it SHALL set gravity-pending and clear the counter.
REQ-008 SHALL implement FSM states IDLE, CHECK, LOCK.
REQ-009 IDLE: if game_en=1 and any request is pending, the FSM SHALL select one request, drive the candidate, assert chk_req and move to CHECK on the next cycle.
REQ-010 Request priority SHALL be gravity > rotate > left/right > soft drop.
REQ-011 Candidates SHALL be:
- gravity and soft drop: (x, y+1, rot).
- rotate: (x, y, rot+1 mod 4); rotation 3 wraps to 0.
- left: (x-1, y, rot).
- right: (x+1, y, rot).
- x and y arithmetic SHALL wrap modulo 2^width; bounds are the checker's job.
REQ-012 CHECK: chk_req and the chk_* outputs SHALL hold stable until chk_done. On chk_done the FSM SHALL clear the served request, deassert chk_req and act on the result the same edge:
- chk_ok=1: commit the candidate to piece_x/piece_y/shape_rot, then go to IDLE.
- chk_ok=0 on a non-gravity request: discard it and go to IDLE.
- chk_ok=0 on a gravity request: go to LOCK.
REQ-013 LOCK: lock_pulse=1 for exactly one cycle. The FSM SHALL load X_SPAWN/Y_SPAWN/0 into piece_x/piece_y/shape_rot, clear all pending requests and the gravity counter, then go to IDLE.
REQ-014 A gravity expiry or key edge arriving during CHECK or LOCK SHALL set its pending flag; it SHALL NOT alter the in-flight candidate. Any key edge arriving during LOCK SHALL be lost.
REQ-015 A committed soft drop SHALL clear the gravity counter.
REQ-016 If game_en falls during CHECK, the FSM SHALL still complete that check. Pending requests SHALL be retained but not served until game_en=1.
REQ-017 Minimum move latency SHALL be: key edge -> chk_req in 2 cycles; chk_done -> committed output update on the next cycle.

Reset
REQ-018 Reset SHALL set:
- FSM to IDLE.
- piece_x=X_SPAWN, piece_y=Y_SPAWN, shape_rot=0.
- chk_req=0, chk_x/chk_y/chk_rot=0, lock_pulse=0.
- gravity counter=0, all pending flags=0, registered keycode=0x0000.
REQ-019 Reset mid-CHECK SHALL abandon the transaction; any chk_done arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-020 Macro SOFT_DROP_EN:
- Defined: S key behaves per REQ-011 and REQ-015.
- Undefined: S key SHALL be ignored, and no soft-drop pending logic SHALL exist.

Verification
REQ-021 Reset, then press W, release, press W: two checks with chk_rot=1 then 2; both chk_ok=1 -> shape_rot=2, and W held for 100 cycles yields only one request.
REQ-022 GRAV_PERIOD=3, game_en=1, checker always ok: after 6 frame_ticks -> piece_y=2, x and rotation unchanged.
REQ-023 A at piece_x=0, checker chk_ok=0 -> piece_x stays 0, no lock_pulse; A at piece_x=4 with ok -> piece_x=3.
REQ-024 Gravity check answered chk_ok=0 at y=17 -> single-cycle lock_pulse, then piece=(4,0,0), counter=0.
REQ-025 Gravity expiry and D edge in the same cycle -> gravity checked first (chk_y=y+1), then D (chk_x=x+1). With SOFT_DROP_EN undefined, S press -> no chk_req.
